// File: rtl/ppc_mem_pkg.sv
// Doubleword memory types shared by the fetch unit, the load unit and the read arbiter.
// Addresses and data use big-endian bit numbering.
package ppc_mem_pkg;

  localparam int ADDR_W = 61;
  localparam int DATA_W = 64;

  typedef logic [0:ADDR_W-1] dword_addr_t;
  typedef logic [0:DATA_W-1] dword_t;

  typedef enum logic [1:0] {
    GRANT_NONE  = 2'b00,
    GRANT_FETCH = 2'b01,
    GRANT_LOAD  = 2'b10,
    GRANT_BOTH  = 2'b11
  } grant_t;

endpackage

// File: rtl/mem_read_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags when the count equals LIMIT.
module sat_counter #(
  parameter int WIDTH = 4,
  parameter int LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] limit_val;

  assign limit_val = LIMIT[WIDTH-1:0];
  assign at_limit  = (count_q == limit_val);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !at_limit) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one combinational-read dword memory port between fetch and load requesters.
// Load wins by default; a starved fetch is forced through, equal addresses coalesce.
module mem_read_arbiter
  import ppc_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int PERF_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  dword_addr_t       f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output dword_t            f_rdata,
  input  logic              l_valid,
  input  dword_addr_t       l_addr,
  output logic              l_ready,
  output logic              l_rvalid,
  output dword_t            l_rdata,
  output dword_addr_t       mem_addr,
  input  dword_t            mem_data,
  output logic [PERF_W-1:0] perf_fetch,
  output logic [PERF_W-1:0] perf_load,
  output logic [PERF_W-1:0] perf_conflict
);

  logic   same_addr;
  logic   conflict;
  logic   starve_at_limit;
  grant_t grant;

  logic   f_rvalid_q, f_rvalid_d;
  logic   l_rvalid_q, l_rvalid_d;
  dword_t f_rdata_q,  f_rdata_d;
  dword_t l_rdata_q,  l_rdata_d;

  logic [PERF_W-1:0] perf_fetch_q,    perf_fetch_d;
  logic [PERF_W-1:0] perf_load_q,     perf_load_d;
  logic [PERF_W-1:0] perf_conflict_q, perf_conflict_d;

  assign same_addr = f_valid && l_valid && (f_addr == l_addr);
  assign conflict  = f_valid && l_valid && !same_addr;

  // Reset blocks all grants so nothing is accepted while the response path is cleared.
  always_comb begin
    grant = GRANT_NONE;
    if (!reset) begin
      if (same_addr) begin
        grant = GRANT_BOTH;
      end else if (conflict) begin
        grant = starve_at_limit ? GRANT_FETCH : GRANT_LOAD;
      end else if (f_valid) begin
        grant = GRANT_FETCH;
      end else if (l_valid) begin
        grant = GRANT_LOAD;
      end
    end
  end

  assign f_ready  = grant[0];
  assign l_ready  = grant[1];
  assign mem_addr = l_ready ? l_addr : f_addr;

  sat_counter #(
    .WIDTH (4),
    .LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (f_valid && !f_ready),
    .clr      (!f_valid || f_ready),
    .at_limit (starve_at_limit)
  );

  always_comb begin
    f_rvalid_d = f_ready;
    l_rvalid_d = l_ready;
    f_rdata_d  = f_rdata_q;
    l_rdata_d  = l_rdata_q;
    if (f_ready) begin
      f_rdata_d = mem_data;
    end
    if (l_ready) begin
      l_rdata_d = mem_data;
    end
  end

  // Counters wrap freely; a coalesced access counts as one fetch and one load.
  always_comb begin
    perf_fetch_d    = perf_fetch_q    + {{(PERF_W-1){1'b0}}, f_ready};
    perf_load_d     = perf_load_q     + {{(PERF_W-1){1'b0}}, l_ready};
    perf_conflict_d = perf_conflict_q + {{(PERF_W-1){1'b0}}, conflict};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_rvalid_q      <= 1'b0;
      l_rvalid_q      <= 1'b0;
      f_rdata_q       <= '0;
      l_rdata_q       <= '0;
      perf_fetch_q    <= '0;
      perf_load_q     <= '0;
      perf_conflict_q <= '0;
    end else begin
      f_rvalid_q      <= f_rvalid_d;
      l_rvalid_q      <= l_rvalid_d;
      f_rdata_q       <= f_rdata_d;
      l_rdata_q       <= l_rdata_d;
      perf_fetch_q    <= perf_fetch_d;
      perf_load_q     <= perf_load_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign f_rvalid      = f_rvalid_q;
  assign l_rvalid      = l_rvalid_q;
  assign f_rdata       = f_rdata_q;
  assign l_rdata       = l_rdata_q;
  assign perf_fetch    = perf_fetch_q;
  assign perf_load     = perf_load_q;
  assign perf_conflict = perf_conflict_q;

endmodule
